// File: rtl/usart_frame_pkg.sv
// usart_frame_pkg
//   Shared definitions for the UART measurement-link framing. The TX control
//   block uses the same package, so the frame layout and the state encoding are
//   defined once, here.
//   Frame layout: [HEADER][LEN][8 payload bytes][optional checksum byte]
//   Contents:
//     ST_IDLE..ST_DONE  frame decoder state encoding
//     HEADER_BYTE       frame start byte ("D")
//     PAYLOAD_BYTES     payload byte count, also the required LEN byte value
//     DATA_W            width of the recovered high/low level counts
package usart_frame_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [7:0] HEADER_BYTE   = 8'h44;
  localparam int         PAYLOAD_BYTES = 8;
  localparam int         DATA_W        = 28;

endpackage

// File: rtl/usart_byte_timeout.sv
// usart_byte_timeout
//   Inter-byte watchdog for the frame decoder. Counts clk cycles while enabled
//   and flags 'expired' in the cycle the count reaches TIMEOUT_CYCLES-1.
//   Ports:
//     clk      in  system clock
//     rst_n    in  asynchronous active-low reset
//     clear    in  restart the count (byte taken, or decoder not inside a frame)
//     enable   in  count this cycle (decoder inside a frame)
//     expired  out inter-byte gap has reached its limit this cycle
module usart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  // Restart after firing so the counter never runs past LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/usart_frame_recv.sv
// usart_frame_recv
//   Receive-side frame decoder for the UART measurement link. Parses
//   [HEADER][LEN][8 payload bytes][opt. checksum] from the UART RX byte core,
//   recovers the 28-bit high/low level counts and announces them with a pulse.
//   Optional feature macro: FRAME_CHECKSUM_EN adds a trailing checksum byte
//   equal to (LEN + sum of payload bytes) mod 256.
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     rx_data      in   [7:0] byte from the UART RX core
//     rx_valid     in   rx_data valid; taken when rx_valid && rx_ready
//     rx_ready     out  low only during the one-cycle DONE state
//     high_level   out  [27:0] high-level count from the last good frame
//     low_level    out  [27:0] low-level count from the last good frame
//     frame_valid  out  1-cycle pulse, outputs updated
//     frame_err    out  1-cycle pulse, frame dropped
//     busy         out  frame in progress
module usart_frame_recv
  import usart_frame_pkg::*;
#(
  parameter logic [7:0] HEADER         = HEADER_BYTE,
  parameter logic [7:0] PAYLOAD_LEN    = 8'(PAYLOAD_BYTES),
  parameter int         TIMEOUT_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] high_level,
  output logic [DATA_W-1:0] low_level,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [2:0] LAST_BYTE = 3'(PAYLOAD_BYTES - 1);
`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_CSUM;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

  logic [2:0]  state;
  logic [2:0]  byte_cnt;
  logic [63:0] shift_reg;
  logic        byte_taken;
  logic        timeout_en;
  logic        timeout_expired;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  csum_acc;
`endif

  assign rx_ready   = (state != ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign byte_taken = rx_valid && rx_ready;
  assign timeout_en = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);

  usart_byte_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (byte_taken || !timeout_en),
    .enable  (timeout_en),
    .expired (timeout_expired)
  );

  // A byte arriving in the expiry cycle takes priority over the timeout.
  // Payload bytes 0-3 land in shift_reg[63:32] (high), 4-7 in [31:0] (low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      shift_reg   <= '0;
      high_level  <= '0;
      low_level   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum_acc    <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (byte_taken && rx_data == HEADER) begin
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (byte_taken) begin
            if (rx_data == PAYLOAD_LEN) begin
              state    <= ST_DATA;
              byte_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
              csum_acc <= rx_data;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end else if (timeout_expired) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (byte_taken) begin
            shift_reg <= {shift_reg[55:0], rx_data};
            byte_cnt  <= byte_cnt + 3'd1;
`ifdef FRAME_CHECKSUM_EN
            csum_acc  <= csum_acc + rx_data;
`endif
            if (byte_cnt == LAST_BYTE) begin
              state <= ST_AFTER_DATA;
            end
          end else if (timeout_expired) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
`ifdef FRAME_CHECKSUM_EN
        ST_CSUM: begin
          if (byte_taken) begin
            if (rx_data == csum_acc) begin
              state <= ST_DONE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end else if (timeout_expired) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
`endif
        ST_DONE: begin
          // Top nibbles must be clear for the 28-bit counts to be in range.
          if (shift_reg[63:60] == 4'h0 && shift_reg[31:28] == 4'h0) begin
            high_level  <= shift_reg[59:32];
            low_level   <= shift_reg[27:0];
            frame_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
